// File: rtl/ahb_pkg.sv
// Shared AHB-lite definitions: transfer types, size encoding, beat addresses, initiator states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;

    localparam logic [1:0] ADDR_PAYLOAD_0 = 2'd0;
    localparam logic [1:0] ADDR_PAYLOAD_1 = 2'd1;
    localparam logic [1:0] ADDR_DATA_SIZE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_LAST_DATA,
        ST_ERR
    } state_t;

endpackage

// File: rtl/ahb_write_initiator_if.sv
// AHB-lite bus between the write initiator (master) and a responder (slave).
interface ahb_write_initiator_if
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 2
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    htrans_t           htrans;
    logic [2:0]        hsize;
    logic [7:0]        hwdata;
    logic              hready;
    logic              hresp;

    modport master (
        output hsel, haddr, hwrite, htrans, hsize, hwdata,
        input  hready, hresp
    );

    modport slave (
        input  hsel, haddr, hwrite, htrans, hsize, hwdata,
        output hready, hresp
    );
endinterface

// File: rtl/ahb_write_initiator.sv
// Issues one 3-beat byte write burst per accepted start; beat-0 address one cycle after start.
// hready low stalls every output in place; a two-cycle ERROR aborts the burst.
module ahb_write_initiator
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       start,
    input  logic [7:0] payload_0_in,
    input  logic [7:0] payload_1_in,
    input  logic [4:0] data_size_in,
    output logic       busy,
    output logic       done,
    output logic       error,
    ahb_write_initiator_if.master bus
);

    state_t            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [7:0]        d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic              hsel_q, hsel_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    htrans_t           htrans_q, htrans_d;
    logic [7:0]        hwdata_q, hwdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              data_phase;
    logic              to_idle;

    function automatic logic [7:0] beat_data(input logic [1:0] b, input logic [7:0] a0,
                                              input logic [7:0] a1, input logic [7:0] a2);
        logic [7:0] r;
        r = a2;
        if (b == ADDR_PAYLOAD_0) r = a0;
        else if (b == ADDR_PAYLOAD_1) r = a1;
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        d0_d     = d0_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        hsel_d   = hsel_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        htrans_d = htrans_q;
        hwdata_d = hwdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        to_idle  = 1'b0;
        // Beat 0's address phase has no data phase behind it, so hresp means nothing there.
        data_phase = (state_q == ST_LAST_DATA) ||
                     ((state_q == ST_XFER) && (beat_q != ADDR_PAYLOAD_0));

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_XFER;
                    beat_d   = ADDR_PAYLOAD_0;
                    d0_d     = payload_0_in;
                    d1_d     = payload_1_in;
                    d2_d     = {3'b000, data_size_in};
                    hsel_d   = 1'b1;
                    haddr_d  = ADDR_W'(ADDR_PAYLOAD_0);
                    hwrite_d = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                    busy_d   = 1'b1;
                end
            end
            ST_XFER: begin
                if (bus.hready && bus.hresp && data_phase) begin
                    to_idle = 1'b1;
                    error_d = 1'b1;
                end else if (bus.hready) begin
                    hwdata_d = beat_data(beat_q, d0_q, d1_q, d2_q);
                    if (beat_q == ADDR_DATA_SIZE) begin
                        state_d  = ST_LAST_DATA;
                        htrans_d = HTRANS_IDLE;
                    end else begin
                        beat_d   = beat_q + 2'd1;
                        haddr_d  = ADDR_W'(beat_q + 2'd1);
                        htrans_d = HTRANS_SEQ;
                    end
                end else if (bus.hresp && data_phase) begin
                    state_d  = ST_ERR;
                    htrans_d = HTRANS_IDLE;
                end
            end
            ST_LAST_DATA: begin
                if (bus.hready) begin
                    to_idle = 1'b1;
                    done_d  = !bus.hresp;
                    error_d = bus.hresp;
                end else if (bus.hresp) begin
                    state_d  = ST_ERR;
                    htrans_d = HTRANS_IDLE;
                end
            end
            ST_ERR: begin
                if (bus.hready) begin
                    to_idle = 1'b1;
                    error_d = 1'b1;
                end
            end
            default: to_idle = 1'b1;
        endcase

        if (to_idle) begin
            state_d  = ST_IDLE;
            hsel_d   = 1'b0;
            haddr_d  = '0;
            hwrite_d = 1'b0;
            htrans_d = HTRANS_IDLE;
            hwdata_d = 8'h00;
            busy_d   = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= ADDR_PAYLOAD_0;
            d0_q     <= 8'h00;
            d1_q     <= 8'h00;
            d2_q     <= 8'h00;
            hsel_q   <= 1'b0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            hsel_q   <= hsel_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            htrans_q <= htrans_d;
            hwdata_q <= hwdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign bus.hsel   = hsel_q;
    assign bus.haddr  = haddr_q;
    assign bus.hwrite = hwrite_q;
    assign bus.htrans = htrans_q;
    assign bus.hsize  = HSIZE_BYTE;
    assign bus.hwdata = hwdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ahb_write_initiator.sv
// Directed bench for ahb_write_initiator: zero-wait burst, wait states, ERROR abort,
// ignored start, back-to-back restart and asynchronous reset mid-burst.
module tb_ahb_write_initiator;
    import ahb_pkg::*;

    logic       pclk;
    logic       preset_n = 1'b1;
    logic       start;
    logic [7:0] payload_0_in;
    logic [7:0] payload_1_in;
    logic [4:0] data_size_in;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;

    ahb_write_initiator_if #(.ADDR_W(2)) bus ();

    ahb_write_initiator #(.ADDR_W(2)) dut (
        .pclk         (pclk),
        .preset_n     (preset_n),
        .start        (start),
        .payload_0_in (payload_0_in),
        .payload_1_in (payload_1_in),
        .data_size_in (data_size_in),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .bus          (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".hsel"},   32'(bus.hsel),   32'd0);
        chk({tag, ".htrans"}, 32'(bus.htrans), 32'(HTRANS_IDLE));
        chk({tag, ".haddr"},  32'(bus.haddr),  32'd0);
        chk({tag, ".hwrite"}, 32'(bus.hwrite), 32'd0);
        chk({tag, ".hwdata"}, 32'(bus.hwdata), 32'd0);
        chk({tag, ".busy"},   32'(busy),       32'd0);
    endtask

    task automatic chk_addr(input string tag, input htrans_t tr, input logic [1:0] a);
        chk({tag, ".hsel"},   32'(bus.hsel),   32'd1);
        chk({tag, ".htrans"}, 32'(bus.htrans), 32'(tr));
        chk({tag, ".haddr"},  32'(bus.haddr),  32'(a));
    endtask

    initial begin
        start        = 1'b0;
        payload_0_in = 8'h00;
        payload_1_in = 8'h00;
        data_size_in = 5'h00;
        bus.hready   = 1'b1;
        bus.hresp    = 1'b0;

        // Reset state
        #1 preset_n = 1'b0;
        #1;
        chk_quiet("rst");
        chk("rst.done",  32'(done),      32'd0);
        chk("rst.error", 32'(error),     32'd0);
        chk("rst.hsize", 32'(bus.hsize), 32'd0);
        tick();
        tick();

        // Zero-wait burst; start on the first edge after release
        preset_n     = 1'b1;
        start        = 1'b1;
        payload_0_in = 8'hA5;
        payload_1_in = 8'h3C;
        data_size_in = 5'h13;
        tick();
        start = 1'b0;
        chk_addr("zw.k1", HTRANS_NONSEQ, 2'd0);
        chk("zw.k1.hwrite", 32'(bus.hwrite), 32'd1);
        chk("zw.k1.busy",   32'(busy),       32'd1);
        chk("zw.k1.hsize",  32'(bus.hsize),  32'd0);
        tick();
        chk_addr("zw.k2", HTRANS_SEQ, 2'd1);
        chk("zw.k2.hwdata", 32'(bus.hwdata), 32'hA5);
        tick();
        chk_addr("zw.k3", HTRANS_SEQ, 2'd2);
        chk("zw.k3.hwdata", 32'(bus.hwdata), 32'h3C);
        tick();
        chk("zw.k4.htrans", 32'(bus.htrans), 32'(HTRANS_IDLE));
        chk("zw.k4.hwdata", 32'(bus.hwdata), 32'h13);
        chk("zw.k4.busy",   32'(busy),       32'd1);
        chk("zw.k4.done",   32'(done),       32'd0);
        tick();
        chk("zw.k5.done", 32'(done), 32'd1);
        chk_quiet("zw.k5");
        tick();
        chk("zw.k6.done", 32'(done), 32'd0);

        // Wait states during beat-1 data phase
        start        = 1'b1;
        payload_0_in = 8'h11;
        payload_1_in = 8'h22;
        data_size_in = 5'h05;
        tick();
        start = 1'b0;
        chk_addr("ws.k1", HTRANS_NONSEQ, 2'd0);
        tick();
        chk("ws.k2.hwdata", 32'(bus.hwdata), 32'h11);
        tick();
        chk_addr("ws.k3", HTRANS_SEQ, 2'd2);
        chk("ws.k3.hwdata", 32'(bus.hwdata), 32'h22);
        bus.hready = 1'b0;
        tick();
        chk_addr("ws.k4", HTRANS_SEQ, 2'd2);
        chk("ws.k4.hwdata", 32'(bus.hwdata), 32'h22);
        tick();
        chk_addr("ws.k5", HTRANS_SEQ, 2'd2);
        chk("ws.k5.hwdata", 32'(bus.hwdata), 32'h22);
        bus.hready = 1'b1;
        tick();
        chk("ws.k6.hwdata", 32'(bus.hwdata), 32'h05);
        chk("ws.k6.done",   32'(done),       32'd0);
        tick();
        chk("ws.k7.done", 32'(done), 32'd1);
        tick();

        // Two-cycle ERROR during beat-0 data phase
        start        = 1'b1;
        payload_0_in = 8'hA5;
        payload_1_in = 8'h3C;
        data_size_in = 5'h13;
        tick();
        start = 1'b0;
        chk_addr("er.k1", HTRANS_NONSEQ, 2'd0);
        tick();
        chk_addr("er.k2", HTRANS_SEQ, 2'd1);
        bus.hresp  = 1'b1;
        bus.hready = 1'b0;
        tick();
        chk("er.k3.htrans", 32'(bus.htrans), 32'(HTRANS_IDLE));
        chk("er.k3.haddr",  32'(bus.haddr),  32'd1);
        chk("er.k3.busy",   32'(busy),       32'd1);
        chk("er.k3.error",  32'(error),      32'd0);
        bus.hready = 1'b1;
        tick();
        bus.hresp = 1'b0;
        chk("er.k4.error", 32'(error), 32'd1);
        chk("er.k4.done",  32'(done),  32'd0);
        chk_quiet("er.k4");
        tick();
        chk("er.k5.error", 32'(error), 32'd0);
        chk("er.k5.done",  32'(done),  32'd0);
        chk_quiet("er.k5");

        // Ignored start and mid-burst input changes, then restart in the done cycle
        start        = 1'b1;
        payload_0_in = 8'h5A;
        payload_1_in = 8'hC3;
        data_size_in = 5'h1F;
        tick();
        start = 1'b0;
        chk_addr("ig.k1", HTRANS_NONSEQ, 2'd0);
        tick();
        chk("ig.k2.hwdata", 32'(bus.hwdata), 32'h5A);
        start        = 1'b1;
        payload_0_in = 8'hFF;
        payload_1_in = 8'hFF;
        data_size_in = 5'h00;
        tick();
        start = 1'b0;
        chk_addr("ig.k3", HTRANS_SEQ, 2'd2);
        chk("ig.k3.hwdata", 32'(bus.hwdata), 32'hC3);
        tick();
        chk("ig.k4.hwdata", 32'(bus.hwdata), 32'h1F);
        chk("ig.k4.htrans", 32'(bus.htrans), 32'(HTRANS_IDLE));
        tick();
        chk("ig.k5.done", 32'(done), 32'd1);
        chk_quiet("ig.k5");
        start        = 1'b1;
        payload_0_in = 8'h01;
        payload_1_in = 8'h02;
        data_size_in = 5'h03;
        tick();
        start = 1'b0;
        chk_addr("rs.k1", HTRANS_NONSEQ, 2'd0);
        chk("rs.k1.done", 32'(done), 32'd0);
        tick();
        chk("rs.k2.hwdata", 32'(bus.hwdata), 32'h01);
        tick();
        chk("rs.k3.hwdata", 32'(bus.hwdata), 32'h02);

        // Asynchronous reset mid-burst, then a clean restart
        preset_n = 1'b0;
        #1;
        chk_quiet("mr");
        chk("mr.done",  32'(done),  32'd0);
        chk("mr.error", 32'(error), 32'd0);
        #2;
        preset_n     = 1'b1;
        start        = 1'b1;
        payload_0_in = 8'h44;
        payload_1_in = 8'h55;
        data_size_in = 5'h0A;
        tick();
        start = 1'b0;
        chk_addr("pr.k1", HTRANS_NONSEQ, 2'd0);
        chk("pr.k1.hwdata", 32'(bus.hwdata), 32'h00);
        chk("pr.k1.hwrite", 32'(bus.hwrite), 32'd1);
        tick();
        chk("pr.k2.hwdata", 32'(bus.hwdata), 32'h44);
        tick();
        chk("pr.k3.hwdata", 32'(bus.hwdata), 32'h55);
        tick();
        chk("pr.k4.hwdata", 32'(bus.hwdata), 32'h0A);
        tick();
        chk("pr.k5.done", 32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
